sprite_palette_arbiter: RTL and testbench
=========================================

Name: sprite_palette_arbiter

Overview:
- Shares one combinational 16-entry sprite palette ROM (4-bit index in, 4/4/4 RGB out) between NUM_REQ sprite pixel fetchers, e.g. player 1 and player 2 crouch/stand renderers.
- Arbitrates per-pixel lookup requests and drives the ROM index.
- Registers the resulting RGB plus transparency flag and source/tag into one output stage with valid/ready toward the frame compositor.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TAG_W, 10, per-pixel tag width (draw X coordinate), passed through unchanged.
- TRANSPARENT_IDX, 0, palette index treated as transparent (magenta key F,0,F).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- fixed_prio  in  1  0 = round-robin; 1 = fixed priority, lowest index wins.
- req_valid  in  NUM_REQ  per-requester lookup valid.
- req_index  in  NUM_REQ x 4  per-requester palette index.
- req_tag  in  NUM_REQ x TAG_W  per-requester pixel tag.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- pal_index  out  4  index driven to the palette ROM.
- pal_red, pal_green, pal_blue  in  4 each  ROM combinational outputs.
- out_valid  out  1  output stage holds a pixel.
- out_ready  in  1  compositor accepts.
- out_src  out  clog2(NUM_REQ)  requester that produced the pixel.
- out_tag  out  TAG_W  tag of that pixel.
- out_red, out_green, out_blue  out  4 each  looked-up colour.
- out_transparent  out  1  1 when the looked-up index == TRANSPARENT_IDX.
- grant_count  out  NUM_REQ x 16  saturating per-requester accepted-lookup counters.

Behaviour:
- Reset (async assert, sync release): out_valid=0; out_src/out_tag/out_rgb/out_transparent=0; rr pointer=0 (requester 0 highest priority next); grant_count all 0.
- While Reset_n=0: req_ready=0 and pal_index=0.
- can_accept = !out_valid || out_ready, so the stage accepts on the same cycle it drains.
- Grant is combinational:
  - At most one req_ready bit is high, and only if can_accept and that requester's req_valid=1.
  - req_ready never asserts for an invalid requester.
- Round-robin:
  - Search starts at rr pointer.
  - On an accepted grant to requester k, pointer becomes (k+1) mod NUM_REQ.
  - Pointer is unchanged when nothing is granted.
- fixed_prio=1: lowest-numbered valid requester wins; pointer still updates as above so a return to RR stays fair.
- pal_index = granted requester's req_index; otherwise holds its last driven value (no glitch toggling when idle).
- Transfer happens when req_ready[k] && req_valid[k].
- On the next clock edge after a transfer:
  - out_valid=1, out_src=k, out_tag=req_tag[k].
  - out_rgb = pal_* sampled that cycle.
  - out_transparent = (req_index[k]==TRANSPARENT_IDX).
- Latency is 1 cycle request-to-output; throughput is 1 pixel/cycle when out_ready stays high.
- Output hold: while out_valid && !out_ready, all out_* stay stable and no grants are issued (backpressure reaches every requester).
- Drain without new grant: out_valid falls to 0 on the next edge; data fields keep their last value.
- Requesters must hold req_valid/index/tag stable until accepted. The block does not check this.
- grant_count[k] increments on each transfer from k and saturates at 16'hFFFF (no wrap).
- Reset mid-transfer drops the in-flight pixel; no partial state survives.

Decomposition:
- Package sprite_pal_pkg holds:
  - rgb12_t struct (red, green, blue, 4 bits each).
  - PAL_IDX_W=4.
  - TRANSPARENT_IDX default.
  - Function idx_is_transparent().
- Sub-module rr_arbiter_onehot (NUM_REQ): inputs req vector, pointer, fixed_prio, enable; output one-hot grant. Pure combinational, reusable for the sprite-ROM fetch arbiter.
- Pointer register, output stage and counters live in the top.

Test Plan:
- Bench palette: index 0 = F,0,F; 4 = 9,0,A; 8 = 8,8,8; 15 = D,0,D.
- Reset: Reset_n=0 mid-run with out_valid=1 -> out_valid=0, all grant_count=0, req_ready=0 immediately (async).
- Single request: req0 valid, index=4, tag=37, out_ready=1 -> next cycle out_valid=1, src=0, tag=37, RGB=9,0,A, out_transparent=0.
- Transparency: req1 index=0 -> out RGB=F,0,F, out_transparent=1, src=1.
- Round-robin: both valid continuously, out_ready=1, fixed_prio=0 -> srcs alternate 0,1,0,1; after 100 cycles grant_count = 50/50.
- Backpressure: out_ready=0 for 5 cycles with output full -> outputs stable, req_ready=0 throughout. Raise out_ready -> drain and new grant on the same edge, no bubble, no duplicate.
- Fixed priority and saturation:
  - fixed_prio=1, both valid -> only src 0 until req0 drops.
  - Force 65536 grants -> grant_count[0] stays 16'hFFFF.

Source files
------------

// File: rtl/sprite_pal_pkg.sv
// Shared types and constants for the sprite palette lookup path.
// Palette entries are 12-bit RGB (4/4/4) addressed by a 4-bit index.
package sprite_pal_pkg;

  localparam int PAL_IDX_W = 4;
  localparam logic [PAL_IDX_W-1:0] TRANSPARENT_IDX = 4'd0;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  function automatic logic idx_is_transparent(input logic [PAL_IDX_W-1:0] idx,
                                              input logic [PAL_IDX_W-1:0] key);
    return idx == key;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational one-hot arbiter: round-robin from ptr, or fixed priority
// (lowest index wins) when fixed_prio is set. No grant when enable is low.
module rr_arbiter_onehot #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               fixed_prio,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int  start;
    int  idx;
    logic found;
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    start = fixed_prio ? 0 : int'(ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (start + i) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Shares one combinational sprite palette ROM between NUM_REQ pixel fetchers
// and registers the looked-up colour into a valid/ready output stage.
module sprite_palette_arbiter
  import sprite_pal_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W = 10,
  parameter logic [3:0] TRANSPARENT_IDX = sprite_pal_pkg::TRANSPARENT_IDX,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     fixed_prio,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*4-1:0]     req_index,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [3:0]               pal_index,
  input  logic [3:0]               pal_red,
  input  logic [3:0]               pal_green,
  input  logic [3:0]               pal_blue,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SRC_W-1:0]         out_src,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_red,
  output logic [3:0]               out_green,
  output logic [3:0]               out_blue,
  output logic                     out_transparent,
  output logic [NUM_REQ*16-1:0]    grant_count
);

  logic [SRC_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic                 can_accept;
  logic                 transfer;
  logic [SRC_W-1:0]     sel_src;
  logic [PAL_IDX_W-1:0] sel_index;
  logic [TAG_W-1:0]     sel_tag;
  logic [PAL_IDX_W-1:0] pal_hold;
  rgb12_t               out_rgb;
  logic [15:0]          cnt [NUM_REQ];

  // Backpressure stalls every requester; reset also suppresses all grants.
  assign can_accept = !out_valid || out_ready;

  rr_arbiter_onehot #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .fixed_prio (fixed_prio),
    .enable     (can_accept && Reset_n),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign transfer  = |(grant & req_valid);

  always_comb begin
    sel_src   = '0;
    sel_index = '0;
    sel_tag   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_src   = SRC_W'(k);
        sel_index = req_index[k*4 +: 4];
        sel_tag   = req_tag[k*TAG_W +: TAG_W];
      end
    end
  end

  // Idle cycles keep the ROM address steady rather than toggling it.
  assign pal_index = transfer ? sel_index : pal_hold;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr          <= '0;
      pal_hold        <= '0;
      out_valid       <= 1'b0;
      out_src         <= '0;
      out_tag         <= '0;
      out_rgb         <= '0;
      out_transparent <= 1'b0;
    end else if (transfer) begin
      rr_ptr          <= (sel_src == SRC_W'(NUM_REQ - 1)) ? '0 : sel_src + 1'b1;
      pal_hold        <= sel_index;
      out_valid       <= 1'b1;
      out_src         <= sel_src;
      out_tag         <= sel_tag;
      out_rgb         <= '{red: pal_red, green: pal_green, blue: pal_blue};
      out_transparent <= idx_is_transparent(sel_index, TRANSPARENT_IDX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_red   = out_rgb.red;
  assign out_green = out_rgb.green;
  assign out_blue  = out_rgb.blue;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[k] && req_valid[k] && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    assign grant_count[k*16 +: 16] = cnt[k];
  end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Self-checking bench: directed stimulus, a per-cycle behavioural model and
// literal expectations for the palette, round-robin, backpressure and saturation.
module tb_sprite_palette_arbiter;

  localparam int N = 2;
  localparam int TW = 10;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          fixed_prio;
  logic [N-1:0]  req_valid;
  logic [N*4-1:0] req_index;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]  req_ready;
  logic [3:0]    pal_index, pal_red, pal_green, pal_blue;
  logic          out_valid, out_ready;
  logic [0:0]    out_src;
  logic [TW-1:0] out_tag;
  logic [3:0]    out_red, out_green, out_blue;
  logic          out_transparent;
  logic [N*16-1:0] grant_count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  function automatic logic [11:0] pal_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 12'hF0F;
      4'd4:    return 12'h90A;
      4'd8:    return 12'h888;
      4'd15:   return 12'hD0D;
      default: return {i, ~i, i ^ 4'h5};
    endcase
  endfunction

  assign {pal_red, pal_green, pal_blue} = pal_lut(pal_index);

  sprite_palette_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .fixed_prio(fixed_prio),
    .req_valid(req_valid), .req_index(req_index), .req_tag(req_tag),
    .req_ready(req_ready), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_tag(out_tag), .out_red(out_red), .out_green(out_green),
    .out_blue(out_blue), .out_transparent(out_transparent),
    .grant_count(grant_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: next requester to favour, current output pixel, per-source counts.
  int          m_ptr;
  logic        m_valid;
  int          m_src;
  logic [TW-1:0] m_tag;
  logic [11:0] m_rgb;
  logic        m_tr;
  int          m_cnt [N];
  logic [3:0]  m_pal;

  always @(negedge Clk) begin
    int g;
    int c;
    logic [3:0] gi;
    if (!Reset_n) begin
      m_ptr = 0; m_valid = 0; m_src = 0; m_tag = '0; m_rgb = '0; m_tr = 0; m_pal = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      check("rst_req_ready", req_ready, 0);
      check("rst_pal_index", pal_index, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_grant_count", grant_count, 0);
    end else begin
      check("m_out_valid", out_valid, m_valid);
      check("m_out_src", out_src, m_src);
      check("m_out_tag", out_tag, m_tag);
      check("m_out_rgb", {out_red, out_green, out_blue}, m_rgb);
      check("m_out_transparent", out_transparent, m_tr);
      for (int k = 0; k < N; k++) check("m_grant_count", grant_count[k*16 +: 16], m_cnt[k]);
      g = -1;
      if (!m_valid || out_ready) begin
        for (int i = 0; i < N; i++) begin
          c = fixed_prio ? i : (m_ptr + i) % N;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      check("m_req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      gi = (g >= 0) ? req_index[g*4 +: 4] : m_pal;
      check("m_pal_index", pal_index, gi);
      if (g >= 0) begin
        m_valid = 1; m_src = g; m_tag = req_tag[g*TW +: TW];
        m_rgb = pal_lut(gi); m_tr = (gi == 4'd0); m_pal = gi;
        if (m_cnt[g] < 65535) m_cnt[g]++;
        m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 0; fixed_prio = 0; req_valid = '0; req_index = '0; req_tag = '0; out_ready = 1;
    repeat (2) step();
    Reset_n = 1;

    // Single request from requester 0.
    req_valid = 2'b01; req_index[3:0] = 4'd4; req_tag[9:0] = 10'd37;
    step();
    check("single_valid", out_valid, 1);
    check("single_src", out_src, 0);
    check("single_tag", out_tag, 37);
    check("single_rgb", {out_red, out_green, out_blue}, 12'h90A);
    check("single_transparent", out_transparent, 0);
    req_valid = '0;

    // Transparent index from requester 1.
    req_valid = 2'b10; req_index[7:4] = 4'd0; req_tag[19:10] = 10'd5;
    step();
    check("transp_src", out_src, 1);
    check("transp_rgb", {out_red, out_green, out_blue}, 12'hF0F);
    check("transp_flag", out_transparent, 1);
    req_valid = '0;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_tag_held", out_tag, 5);

    // Asynchronous reset with a pixel in the output stage.
    req_valid = 2'b01; req_index[3:0] = 4'd4;
    step();
    check("pre_rst_valid", out_valid, 1);
    Reset_n = 0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", req_ready, 0);
    check("async_rst_count", grant_count, 0);
    check("async_rst_pal", pal_index, 0);
    step();
    step();
    Reset_n = 1;

    // Round-robin with both requesters busy.
    req_valid = 2'b11; req_index = {4'd15, 4'd8}; req_tag = {10'd200, 10'd100};
    for (int i = 0; i < 100; i++) begin
      step();
      check("rr_src", out_src, i % 2);
    end
    check("rr_count", grant_count, {16'd50, 16'd50});

    // Backpressure: output full from requester 1, then drain with no bubble.
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", req_ready, 0);
      step();
      check("bp_valid", out_valid, 1);
      check("bp_src", out_src, 1);
      check("bp_tag", out_tag, 200);
      check("bp_rgb", {out_red, out_green, out_blue}, 12'hD0D);
      check("bp_count", grant_count, {16'd50, 16'd50});
    end
    out_ready = 1;
    #1;
    check("bp_release_ready", req_ready, 2'b01);
    step();
    check("bp_release_valid", out_valid, 1);
    check("bp_release_src", out_src, 0);
    check("bp_release_count", grant_count, {16'd50, 16'd51});

    // Fixed priority: requester 0 always wins while valid.
    fixed_prio = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("fixed_src", out_src, 0);
    end
    req_valid = 2'b10;
    step();
    check("fixed_drop_src", out_src, 1);
    check("fixed_count", grant_count, {16'd51, 16'd56});

    // Saturation of requester 0's counter.
    req_valid = 2'b01;
    repeat (65536) step();
    check("sat_count0", grant_count[15:0], 16'hFFFF);
    step();
    check("sat_count0_hold", grant_count[15:0], 16'hFFFF);
    check("sat_count1", grant_count[31:16], 16'd51);
    req_valid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
